// File: rtl/riscv_core_scoreboard.sv
// Dual-issue scoreboard: issue gating, operand bypass selection, X0..W lane tracking
// and ROB fill generation for the IO2I core.
module riscv_core_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       iss_val_1,
  input  logic [4:0] iss_rd_1,
  input  logic       iss_wen_1,
  input  logic       iss_fu_1,
  input  logic [3:0] iss_rob_slot_1,
  input  logic [4:0] iss_rs1_1,
  input  logic [4:0] iss_rs2_1,
  input  logic       iss_rs1_en_1,
  input  logic       iss_rs2_en_1,
  output logic       iss_rdy_1,
  input  logic       iss_val_2,
  input  logic [4:0] iss_rd_2,
  input  logic       iss_wen_2,
  input  logic       iss_fu_2,
  input  logic [3:0] iss_rob_slot_2,
  input  logic [4:0] iss_rs1_2,
  input  logic [4:0] iss_rs2_2,
  input  logic       iss_rs1_en_2,
  input  logic       iss_rs2_en_2,
  output logic       iss_rdy_2,
  output logic [2:0] op0_byp_sel_1,
  output logic [2:0] op1_byp_sel_1,
  output logic [3:0] op0_rob_slot_1,
  output logic [3:0] op1_rob_slot_1,
  output logic [2:0] op0_byp_sel_2,
  output logic [2:0] op1_byp_sel_2,
  output logic [3:0] op0_rob_slot_2,
  output logic [3:0] op1_rob_slot_2,
  output logic       rob_fill_val_1,
  output logic [3:0] rob_fill_slot_1,
  output logic       rob_fill_val_2,
  output logic [3:0] rob_fill_slot_2,
  input  logic       rob_commit_wen_1,
  input  logic [4:0] rob_commit_rf_waddr_1,
  input  logic [3:0] rob_commit_slot_1,
  input  logic       rob_commit_wen_2,
  input  logic [4:0] rob_commit_rf_waddr_2,
  input  logic [3:0] rob_commit_slot_2
);

  localparam logic [2:0] ST_X0   = 3'd0;
  localparam logic [2:0] ST_X3   = 3'd3;
  localparam logic [2:0] ST_ROB  = 3'd5;
  localparam logic [2:0] SEL_ROB = 3'd6;

  typedef struct packed {
    logic       rdy;
    logic [2:0] sel;
    logic [3:0] slot;
  } opnd_t;

  logic [31:0] pend_q, pend_d;
  logic [31:0] fu_q, fu_d;
  logic [3:0]  slot_q [32];
  logic [3:0]  slot_d [32];
  logic [2:0]  stage_q [32];
  logic [2:0]  stage_d [32];

  logic [31:0] reg_rdy;
  logic [2:0]  reg_sel [32];

  logic [4:0]  lv1_q, lv2_q;
  logic [3:0]  ls1_q [5];
  logic [3:0]  ls2_q [5];

  opnd_t a1, b1, a2, b2;
  logic  raw_12, fire_1, fire_2;

  function automatic opnd_t opnd(input logic en, input logic [4:0] rs, input logic rdy,
                                 input logic [2:0] sel, input logic [3:0] slot);
    opnd_t o;
    o.rdy  = 1'b1;
    o.sel  = 3'd0;
    o.slot = 4'd0;
    if (en && rs != 5'd0) begin
      o.rdy = rdy;
      o.sel = sel;
      if (sel == SEL_ROB) o.slot = slot;
    end
    return o;
  endfunction

  // Per-register view: a MULDIV result only becomes forwardable once it reaches X3
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      reg_rdy[r] = !pend_q[r] || !fu_q[r] || (stage_q[r] >= ST_X3);
      reg_sel[r] = !pend_q[r] ? 3'd0 :
                   (stage_q[r] >= ST_ROB) ? SEL_ROB : stage_q[r] + 3'd1;
    end
  end

  assign a1 = opnd(iss_rs1_en_1, iss_rs1_1, reg_rdy[iss_rs1_1], reg_sel[iss_rs1_1], slot_q[iss_rs1_1]);
  assign b1 = opnd(iss_rs2_en_1, iss_rs2_1, reg_rdy[iss_rs2_1], reg_sel[iss_rs2_1], slot_q[iss_rs2_1]);
  assign a2 = opnd(iss_rs1_en_2, iss_rs1_2, reg_rdy[iss_rs1_2], reg_sel[iss_rs1_2], slot_q[iss_rs1_2]);
  assign b2 = opnd(iss_rs2_en_2, iss_rs2_2, reg_rdy[iss_rs2_2], reg_sel[iss_rs2_2], slot_q[iss_rs2_2]);

  assign raw_12 = iss_val_1 && iss_wen_1 && (iss_rd_1 != 5'd0) &&
                  ((iss_rs1_en_2 && iss_rs1_2 == iss_rd_1) ||
                   (iss_rs2_en_2 && iss_rs2_2 == iss_rd_1));

  assign iss_rdy_1 = a1.rdy && b1.rdy;
  assign iss_rdy_2 = iss_rdy_1 && a2.rdy && b2.rdy && !raw_12;
  assign fire_1    = iss_val_1 && iss_rdy_1;
  assign fire_2    = fire_1 && iss_val_2 && iss_rdy_2;

  assign op0_byp_sel_1  = a1.sel;
  assign op1_byp_sel_1  = b1.sel;
  assign op0_rob_slot_1 = a1.slot;
  assign op1_rob_slot_1 = b1.slot;
  assign op0_byp_sel_2  = a2.sel;
  assign op1_byp_sel_2  = b2.sel;
  assign op0_rob_slot_2 = a2.slot;
  assign op1_rob_slot_2 = b2.slot;

  // Next state: advance, then slot-matched commit clears, then issue (instr 2 last so it wins)
  always_comb begin
    pend_d = pend_q;
    fu_d   = fu_q;
    for (int r = 0; r < 32; r++) begin
      slot_d[r]  = slot_q[r];
      stage_d[r] = (stage_q[r] >= ST_ROB) ? ST_ROB : stage_q[r] + 3'd1;
    end
    if (rob_commit_wen_1 && slot_q[rob_commit_rf_waddr_1] == rob_commit_slot_1)
      pend_d[rob_commit_rf_waddr_1] = 1'b0;
    if (rob_commit_wen_2 && slot_q[rob_commit_rf_waddr_2] == rob_commit_slot_2)
      pend_d[rob_commit_rf_waddr_2] = 1'b0;
    if (fire_1 && iss_wen_1 && iss_rd_1 != 5'd0) begin
      pend_d[iss_rd_1]  = 1'b1;
      fu_d[iss_rd_1]    = iss_fu_1;
      slot_d[iss_rd_1]  = iss_rob_slot_1;
      stage_d[iss_rd_1] = ST_X0;
    end
    if (fire_2 && iss_wen_2 && iss_rd_2 != 5'd0) begin
      pend_d[iss_rd_2]  = 1'b1;
      fu_d[iss_rd_2]    = iss_fu_2;
      slot_d[iss_rd_2]  = iss_rob_slot_2;
      stage_d[iss_rd_2] = ST_X0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
    fu_q <= fu_d;
    for (int r = 0; r < 32; r++) begin
      slot_q[r]  <= slot_d[r];
      stage_q[r] <= stage_d[r];
    end
  end

  // Issue -> X0 -> X1 -> X2 -> X3 -> W lanes; never stall
  always_ff @(posedge clk) begin
    if (reset) begin
      lv1_q <= '0;
      lv2_q <= '0;
    end else begin
      lv1_q <= {lv1_q[3:0], fire_1};
      lv2_q <= {lv2_q[3:0], fire_2};
    end
    ls1_q[0] <= iss_rob_slot_1;
    ls2_q[0] <= iss_rob_slot_2;
    for (int s = 1; s < 5; s++) begin
      ls1_q[s] <= ls1_q[s-1];
      ls2_q[s] <= ls2_q[s-1];
    end
  end

  assign rob_fill_val_1  = lv1_q[4];
  assign rob_fill_slot_1 = lv1_q[4] ? ls1_q[4] : 4'd0;
  assign rob_fill_val_2  = lv2_q[4];
  assign rob_fill_slot_2 = lv2_q[4] ? ls2_q[4] : 4'd0;

endmodule

// File: tb/tb_riscv_core_scoreboard.sv
// Randomized bench for riscv_core_scoreboard against a cycle-age reference model,
// plus directed literal checks.
module tb_riscv_core_scoreboard;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       iss_val_1, iss_wen_1, iss_fu_1, iss_rs1_en_1, iss_rs2_en_1, iss_rdy_1;
  logic       iss_val_2, iss_wen_2, iss_fu_2, iss_rs1_en_2, iss_rs2_en_2, iss_rdy_2;
  logic [4:0] iss_rd_1, iss_rs1_1, iss_rs2_1, iss_rd_2, iss_rs1_2, iss_rs2_2;
  logic [3:0] iss_rob_slot_1, iss_rob_slot_2;
  logic [2:0] op0_byp_sel_1, op1_byp_sel_1, op0_byp_sel_2, op1_byp_sel_2;
  logic [3:0] op0_rob_slot_1, op1_rob_slot_1, op0_rob_slot_2, op1_rob_slot_2;
  logic       rob_fill_val_1, rob_fill_val_2;
  logic [3:0] rob_fill_slot_1, rob_fill_slot_2;
  logic       rob_commit_wen_1, rob_commit_wen_2;
  logic [4:0] rob_commit_rf_waddr_1, rob_commit_rf_waddr_2;
  logic [3:0] rob_commit_slot_1, rob_commit_slot_2;

  riscv_core_scoreboard dut (
    .clk(clk), .reset(reset),
    .iss_val_1(iss_val_1), .iss_rd_1(iss_rd_1), .iss_wen_1(iss_wen_1), .iss_fu_1(iss_fu_1),
    .iss_rob_slot_1(iss_rob_slot_1), .iss_rs1_1(iss_rs1_1), .iss_rs2_1(iss_rs2_1),
    .iss_rs1_en_1(iss_rs1_en_1), .iss_rs2_en_1(iss_rs2_en_1), .iss_rdy_1(iss_rdy_1),
    .iss_val_2(iss_val_2), .iss_rd_2(iss_rd_2), .iss_wen_2(iss_wen_2), .iss_fu_2(iss_fu_2),
    .iss_rob_slot_2(iss_rob_slot_2), .iss_rs1_2(iss_rs1_2), .iss_rs2_2(iss_rs2_2),
    .iss_rs1_en_2(iss_rs1_en_2), .iss_rs2_en_2(iss_rs2_en_2), .iss_rdy_2(iss_rdy_2),
    .op0_byp_sel_1(op0_byp_sel_1), .op1_byp_sel_1(op1_byp_sel_1),
    .op0_rob_slot_1(op0_rob_slot_1), .op1_rob_slot_1(op1_rob_slot_1),
    .op0_byp_sel_2(op0_byp_sel_2), .op1_byp_sel_2(op1_byp_sel_2),
    .op0_rob_slot_2(op0_rob_slot_2), .op1_rob_slot_2(op1_rob_slot_2),
    .rob_fill_val_1(rob_fill_val_1), .rob_fill_slot_1(rob_fill_slot_1),
    .rob_fill_val_2(rob_fill_val_2), .rob_fill_slot_2(rob_fill_slot_2),
    .rob_commit_wen_1(rob_commit_wen_1), .rob_commit_rf_waddr_1(rob_commit_rf_waddr_1),
    .rob_commit_slot_1(rob_commit_slot_1),
    .rob_commit_wen_2(rob_commit_wen_2), .rob_commit_rf_waddr_2(rob_commit_rf_waddr_2),
    .rob_commit_slot_2(rob_commit_slot_2)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each tracked register remembers the cycle it was issued in;
  // its bypass select is simply its age in cycles, capped at 6 (ROB).
  bit       m_pend [32];
  bit       m_fu   [32];
  bit [3:0] m_slot [32];
  int       m_icyc [32];
  bit       hv1 [8];
  bit       hv2 [8];
  bit [3:0] hs1 [8];
  bit [3:0] hs2 [8];
  int       cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void exp_op(input bit en, input logic [4:0] rs,
                                 output bit rdy, output int sel, output int slot);
    int age;
    rdy = 1'b1; sel = 0; slot = 0;
    if (en && rs != 5'd0 && m_pend[rs]) begin
      age  = cyc - m_icyc[rs];
      sel  = (age > 6) ? 6 : age;
      rdy  = !m_fu[rs] || age >= 4;
      if (sel == 6) slot = int'(m_slot[rs]);
    end
  endfunction

  always @(negedge clk) begin : cmp
    bit r1a, r1b, r2a, r2b, e1, e2, haz, f1, f2, c1, c2;
    int s1a, s1b, s2a, s2b, t1a, t1b, t2a, t2b, idx;
    if (!reset) begin
      exp_op(iss_rs1_en_1, iss_rs1_1, r1a, s1a, t1a);
      exp_op(iss_rs2_en_1, iss_rs2_1, r1b, s1b, t1b);
      exp_op(iss_rs1_en_2, iss_rs1_2, r2a, s2a, t2a);
      exp_op(iss_rs2_en_2, iss_rs2_2, r2b, s2b, t2b);
      haz = iss_val_1 && iss_wen_1 && iss_rd_1 != 5'd0 &&
            ((iss_rs1_en_2 && iss_rs1_2 == iss_rd_1) || (iss_rs2_en_2 && iss_rs2_2 == iss_rd_1));
      e1 = r1a && r1b;
      e2 = e1 && r2a && r2b && !haz;
      chk("iss_rdy_1", int'(iss_rdy_1), int'(e1));
      chk("iss_rdy_2", int'(iss_rdy_2), int'(e2));
      if (r1a) begin chk("op0_sel_1", int'(op0_byp_sel_1), s1a); chk("op0_slot_1", int'(op0_rob_slot_1), t1a); end
      if (r1b) begin chk("op1_sel_1", int'(op1_byp_sel_1), s1b); chk("op1_slot_1", int'(op1_rob_slot_1), t1b); end
      if (r2a) begin chk("op0_sel_2", int'(op0_byp_sel_2), s2a); chk("op0_slot_2", int'(op0_rob_slot_2), t2a); end
      if (r2b) begin chk("op1_sel_2", int'(op1_byp_sel_2), s2b); chk("op1_slot_2", int'(op1_rob_slot_2), t2b); end
      idx = (cyc + 3) % 8;
      chk("fill_val_1", int'(rob_fill_val_1), int'(hv1[idx]));
      chk("fill_val_2", int'(rob_fill_val_2), int'(hv2[idx]));
      if (hv1[idx]) chk("fill_slot_1", int'(rob_fill_slot_1), int'(hs1[idx]));
      if (hv2[idx]) chk("fill_slot_2", int'(rob_fill_slot_2), int'(hs2[idx]));
      f1 = iss_val_1 && e1;
      f2 = f1 && iss_val_2 && e2;
      c1 = rob_commit_wen_1 && m_pend[rob_commit_rf_waddr_1] && m_slot[rob_commit_rf_waddr_1] == rob_commit_slot_1;
      c2 = rob_commit_wen_2 && m_pend[rob_commit_rf_waddr_2] && m_slot[rob_commit_rf_waddr_2] == rob_commit_slot_2;
      if (c1) m_pend[rob_commit_rf_waddr_1] = 1'b0;
      if (c2) m_pend[rob_commit_rf_waddr_2] = 1'b0;
      if (f1 && iss_wen_1 && iss_rd_1 != 5'd0) begin
        m_pend[iss_rd_1] = 1'b1; m_fu[iss_rd_1] = iss_fu_1;
        m_slot[iss_rd_1] = iss_rob_slot_1; m_icyc[iss_rd_1] = cyc;
      end
      if (f2 && iss_wen_2 && iss_rd_2 != 5'd0) begin
        m_pend[iss_rd_2] = 1'b1; m_fu[iss_rd_2] = iss_fu_2;
        m_slot[iss_rd_2] = iss_rob_slot_2; m_icyc[iss_rd_2] = cyc;
      end
      hv1[cyc % 8] = f1; hs1[cyc % 8] = iss_rob_slot_1;
      hv2[cyc % 8] = f2; hs2[cyc % 8] = iss_rob_slot_2;
    end else begin
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      for (int i = 0; i < 8; i++) begin hv1[i] = 1'b0; hv2[i] = 1'b0; end
    end
    cyc++;
  end

  task automatic idle();
    iss_val_1 = 0; iss_wen_1 = 0; iss_fu_1 = 0; iss_rd_1 = 0; iss_rob_slot_1 = 0;
    iss_rs1_1 = 0; iss_rs2_1 = 0; iss_rs1_en_1 = 0; iss_rs2_en_1 = 0;
    iss_val_2 = 0; iss_wen_2 = 0; iss_fu_2 = 0; iss_rd_2 = 0; iss_rob_slot_2 = 0;
    iss_rs1_2 = 0; iss_rs2_2 = 0; iss_rs1_en_2 = 0; iss_rs2_en_2 = 0;
    rob_commit_wen_1 = 0; rob_commit_rf_waddr_1 = 0; rob_commit_slot_1 = 0;
    rob_commit_wen_2 = 0; rob_commit_rf_waddr_2 = 0; rob_commit_slot_2 = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic issue1(input logic [4:0] rd, input logic fu, input logic [3:0] slot);
    iss_val_1 = 1; iss_wen_1 = 1; iss_rd_1 = rd; iss_fu_1 = fu; iss_rob_slot_1 = slot;
  endtask

  task automatic read1(input logic [4:0] rs);
    iss_rs1_en_1 = 1; iss_rs1_1 = rs;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // reset state
    @(negedge clk);
    chk("rst_rdy_1", int'(iss_rdy_1), 1); chk("rst_rdy_2", int'(iss_rdy_2), 1);
    chk("rst_sel", int'(op0_byp_sel_1), 0); chk("rst_slot", int'(op0_rob_slot_2), 0);
    chk("rst_fill_val", int'(rob_fill_val_1), 0); chk("rst_fill_slot", int'(rob_fill_slot_1), 0);
    nxt();

    // ALU x5 slot 0: bypass from X0 next cycle, fill at t+5, ROB select at t+6
    issue1(5'd5, 1'b0, 4'd0);
    @(negedge clk); chk("alu_issue_rdy", int'(iss_rdy_1), 1); nxt();
    read1(5'd5);
    @(negedge clk); chk("alu_t1_rdy", int'(iss_rdy_1), 1); chk("alu_t1_sel", int'(op0_byp_sel_1), 1); nxt();
    for (int i = 2; i < 5; i++) begin
      @(negedge clk); chk("alu_early_fill", int'(rob_fill_val_1), 0); nxt();
    end
    @(negedge clk); chk("alu_t5_fill", int'(rob_fill_val_1), 1); chk("alu_t5_slot", int'(rob_fill_slot_1), 0); nxt();
    read1(5'd5);
    @(negedge clk); chk("alu_t6_sel", int'(op0_byp_sel_1), 6); chk("alu_t6_slot", int'(op0_rob_slot_1), 0);
    chk("alu_t6_fill", int'(rob_fill_val_1), 0); nxt();

    // MULDIV x6 slot 3
    issue1(5'd6, 1'b1, 4'd3);
    @(negedge clk); nxt();
    for (int i = 1; i < 4; i++) begin
      read1(5'd6); @(negedge clk); chk("mul_stall", int'(iss_rdy_1), 0); nxt();
    end
    read1(5'd6); @(negedge clk); chk("mul_t4_rdy", int'(iss_rdy_1), 1); chk("mul_t4_sel", int'(op0_byp_sel_1), 4); nxt();
    read1(5'd6); @(negedge clk); chk("mul_t5_sel", int'(op0_byp_sel_1), 5);
    chk("mul_t5_fill", int'(rob_fill_val_1), 1); chk("mul_t5_fslot", int'(rob_fill_slot_1), 3); nxt();
    read1(5'd6);
    rob_commit_wen_1 = 1; rob_commit_rf_waddr_1 = 5'd6; rob_commit_slot_1 = 4'd3;
    @(negedge clk); chk("mul_t6_sel", int'(op0_byp_sel_1), 6); chk("mul_t6_slot", int'(op0_rob_slot_1), 3); nxt();
    read1(5'd6); @(negedge clk); chk("mul_commit_sel", int'(op0_byp_sel_1), 0); nxt();

    // intra-pair RAW, then instruction 1 stalled
    issue1(5'd7, 1'b1, 4'd5);
    iss_val_2 = 1; iss_rs2_en_2 = 1; iss_rs2_2 = 5'd7; iss_rob_slot_2 = 4'd6;
    @(negedge clk); chk("pair_rdy_1", int'(iss_rdy_1), 1); chk("pair_rdy_2", int'(iss_rdy_2), 0); nxt();
    iss_val_1 = 1; read1(5'd7); iss_val_2 = 1;
    @(negedge clk); chk("stall_rdy_1", int'(iss_rdy_1), 0); chk("stall_rdy_2", int'(iss_rdy_2), 0); nxt();

    // WAW on x8: slot 2 then slot 3
    issue1(5'd8, 1'b0, 4'd2); @(negedge clk); nxt();
    issue1(5'd8, 1'b0, 4'd3); @(negedge clk); nxt();
    repeat (7) begin @(negedge clk); nxt(); end
    iss_rs2_en_1 = 1; iss_rs2_1 = 5'd8;
    rob_commit_wen_2 = 1; rob_commit_rf_waddr_2 = 5'd8; rob_commit_slot_2 = 4'd2;
    @(negedge clk); chk("waw_sel_a", int'(op1_byp_sel_1), 6); chk("waw_slot_a", int'(op1_rob_slot_1), 3); nxt();
    iss_rs2_en_1 = 1; iss_rs2_1 = 5'd8;
    rob_commit_wen_1 = 1; rob_commit_rf_waddr_1 = 5'd8; rob_commit_slot_1 = 4'd3;
    @(negedge clk); chk("waw_sel_b", int'(op1_byp_sel_1), 6); chk("waw_slot_b", int'(op1_rob_slot_1), 3); nxt();
    iss_rs2_en_1 = 1; iss_rs2_1 = 5'd8;
    @(negedge clk); chk("waw_cleared", int'(op1_byp_sel_1), 0); nxt();

    // write to x0 is never tracked
    issue1(5'd0, 1'b1, 4'd1); @(negedge clk); nxt();
    read1(5'd0);
    @(negedge clk); chk("x0_rdy", int'(iss_rdy_1), 1); chk("x0_sel", int'(op0_byp_sel_1), 0); nxt();

    // reset at t+2 discards the in-flight instruction
    issue1(5'd10, 1'b0, 4'd9); @(negedge clk); nxt();
    @(negedge clk); nxt();
    reset = 1; @(negedge clk); nxt(); reset = 0;
    @(negedge clk); nxt();
    @(negedge clk); nxt();
    @(negedge clk); chk("rst_no_fill", int'(rob_fill_val_1), 0); nxt();

    // randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(299) == 0);
      iss_val_1      = ($urandom_range(9) < 7);
      iss_wen_1      = ($urandom_range(3) != 0);
      iss_fu_1       = ($urandom_range(3) == 0);
      iss_rd_1       = 5'($urandom_range(7));
      iss_rob_slot_1 = 4'($urandom_range(15));
      iss_rs1_1      = 5'($urandom_range(7));
      iss_rs2_1      = 5'($urandom_range(7));
      iss_rs1_en_1   = $urandom_range(1) == 1;
      iss_rs2_en_1   = $urandom_range(1) == 1;
      iss_val_2      = ($urandom_range(9) < 7);
      iss_wen_2      = ($urandom_range(3) != 0);
      iss_fu_2       = ($urandom_range(3) == 0);
      iss_rd_2       = 5'($urandom_range(7));
      iss_rob_slot_2 = 4'($urandom_range(15));
      iss_rs1_2      = 5'($urandom_range(7));
      iss_rs2_2      = 5'($urandom_range(7));
      iss_rs1_en_2   = $urandom_range(1) == 1;
      iss_rs2_en_2   = $urandom_range(1) == 1;
      rob_commit_wen_1      = ($urandom_range(2) == 0);
      rob_commit_rf_waddr_1 = 5'($urandom_range(7));
      rob_commit_slot_1     = ($urandom_range(1) == 1) ? m_slot[rob_commit_rf_waddr_1] : 4'($urandom_range(15));
      rob_commit_wen_2      = ($urandom_range(2) == 0);
      rob_commit_rf_waddr_2 = 5'($urandom_range(7));
      rob_commit_slot_2     = ($urandom_range(1) == 1) ? m_slot[rob_commit_rf_waddr_2] : 4'($urandom_range(15));
      @(negedge clk);
      @(posedge clk); #1;
    end
    reset = 0;
    idle();
    @(negedge clk);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_core_scoreboard.md
# riscv_core_scoreboard

Dual-issue scoreboard and pipeline tracker for the IO2I core, between decode/issue and the reorder buffer. Each cycle it decides whether the two oldest decoded instructions may issue, picks a bypass source for every source operand, and follows every issued instruction through the fixed X0–X3/W pipeline. When an instruction reaches W it raises the ROB fill for its slot. It tracks each register until the ROB commits the matching slot.

## Interface
- No parameters: 32 architectural registers, 16-entry ROB (4-bit slots), 5 tracked stages X0, X1, X2, X3, W.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- iss_val_k  in  1  instruction k (k = 1, 2) wants to issue; k=2 is younger
- iss_rd_k  in  5  destination register
- iss_wen_k  in  1  instruction writes rd
- iss_fu_k  in  1  0 = ALU (result at end of X0), 1 = MULDIV (result at end of X3)
- iss_rob_slot_k  in  4  ROB slot already allocated for this instruction
- iss_rs1_k, iss_rs2_k  in  5  source registers
- iss_rs1_en_k, iss_rs2_en_k  in  1  source is read
- iss_rdy_k  out  1  instruction k issues this cycle if iss_val_k is high
- op0_byp_sel_k, op1_byp_sel_k  out  3  rs1/rs2 source: 0 RF, 1 X0, 2 X1, 3 X2, 4 X3, 5 W, 6 ROB
- op0_rob_slot_k, op1_rob_slot_k  out  4  ROB slot to read when the matching select is 6; otherwise 0
- rob_fill_val_k  out  1  instruction in W lane k writes its ROB slot this cycle
- rob_fill_slot_k  out  4  that slot
- rob_commit_wen_k  in  1  ROB commits a register write
- rob_commit_rf_waddr_k  in  5  committed register
- rob_commit_slot_k  in  4  committed slot

## Operation
- Per-register state: pending, fu, slot[3:0], stage[2:0] (X0..W, then ROB).
- Pipeline lanes: 2 lanes × 5 stages of {val, slot}. They shift every cycle and never stall. The W stage drives rob_fill_*.
- Operand availability, judged per source:
  - rs disabled, or rs = x0: ready, sel 0.
  - rs not pending: ready, sel 0.
  - rs pending and fu = ALU: ready, sel = producer stage (1–5), or 6 plus slot once the producer is in ROB.
  - rs pending and fu = MULDIV: ready only at stage X3 or later.
- iss_rdy_1 is high when every enabled source of instruction 1 is ready.
- iss_rdy_2 is high only when all of the following hold:
  - iss_rdy_1 is high;
  - every enabled source of instruction 2 is ready;
  - no enabled source of instruction 2 equals iss_rd_1 while iss_val_1, iss_wen_1 are high and iss_rd_1 ≠ 0.
- Issue rules:
  - Instruction k issues when iss_val_k && iss_rdy_k.
  - Instruction 2 is ignored unless instruction 1 also issues.
  - The issue stage asserts iss_val_k only while the ROB allocation is ready.
- Issue update, when wen and rd ≠ 0: set pending, fu, slot; stage ← X0. If both instructions write the same rd, instruction 2 wins.
- Each cycle every pending register advances one stage; it saturates at ROB after W.
- Commit clears pending[rd] only when rob_commit_slot_k equals the stored slot (WAW-safe). On the same edge, an issue to the same rd overrides the clear.
- Reset clears all pending bits and pipeline valids.

## Timing
- An instruction issued in cycle t occupies X0 in t+1, X1 in t+2, X2 in t+3, X3 in t+4 and W in t+5.
- rob_fill_val is high in t+5. From t+6 the source select is 6 (ROB).
- iss_rdy_k, the selects and the op slots are combinational from state and inputs. All state updates on the rising edge.
- Reset values:
  - rob_fill_val_k = 0, rob_fill_slot_k = 0.
  - With no inputs asserted: iss_rdy_1 = 1 and iss_rdy_2 = 1, all selects 0, all op slots 0.
- A reset in the middle of operation discards everything in flight. No fill is raised for instructions already issued.
- Two fills in one cycle are legal: lane 1 fill is the older instruction.
- Slot compare uses the full 4 bits. ROB wrap-around needs no special handling.

## Test plan
- After reset: issue ALU rd=x5, slot 0 in cycle 1 → rob_fill_val_1 = 1 and rob_fill_slot_1 = 0 in cycle 6 only.
- ALU x5 issued in t; reader with rs1 = x5 in t+1 → iss_rdy_1 = 1 and op0_byp_sel_1 = 1. Reader in t+6 → sel 6, op0_rob_slot_1 = slot.
- MULDIV x6, slot 3, issued in t:
  - reader in t+1..t+3 → iss_rdy_1 = 0;
  - in t+4 → sel 4; in t+5 → sel 5;
  - after commit of x6/slot 3 → sel 0.
- Pair with instruction 1 rd = x7 and instruction 2 rs2 = x7 → iss_rdy_1 = 1, iss_rdy_2 = 0. With instruction 1 not ready, iss_rdy_2 = 0 regardless of its own sources.
- WAW: x8 issued with slot 2, then x8 with slot 3:
  - commit x8/slot 2 → x8 stays pending, readers track slot 3;
  - commit x8/slot 3 → pending clears.
- Write to x0 → nothing is tracked and readers of x0 get sel 0. Reset in t+2 after an issue → no fill in t+5.
